cmd_uart_wrapper: RTL
=====================

Name: cmd_uart_wrapper

Overview:
- Knight-side endpoint of the remote command link.
- Receives 16-bit commands from the remote host as two UART bytes (high byte first) and presents them to the command processor with a ready/clear handshake.
- Serializes the 8-bit response byte (e.g. 8'hA5 positive ack) back to the host.
- Sits between the RX/TX pins and the command FSM, replacing the bit-level UART plus byte-assembly logic.

Parameters:
- BAUD_DIV, 5208, clocks per UART bit (50 MHz / 9600 baud). Benches use 16.
- BYTE_TIMEOUT, 1_000_000, max clocks from the high byte's stop-bit sample to the low byte's start bit before the partial command is discarded.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- RX  input  1  asynchronous serial in, idles high
- TX  output  1  serial out, idles high
- cmd  output  16  last complete command {high_byte, low_byte}
- cmd_rdy  output  1  complete command available
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
- resp  input  8  response byte to send
- trmt  input  1  single-cycle pulse; start sending resp
- tx_done  output  1  response transmission finished

Behaviour:
- Reset (sync, rst=1 at a clk edge): TX=1, cmd=0, cmd_rdy=0, tx_done=0. RX synchronizer preset to 1; all FSMs to IDLE/HIGH; counters 0. Reset mid-frame aborts both RX and TX immediately.
- RX sync: two flops before any use. A start is a 1->0 transition of the synchronized RX while RX is IDLE.
- RX bit engine, states IDLE, START, DATA, STOP:
  - START: sample at BAUD_DIV/2. If the sample is 1, it is a glitch: return to IDLE.
  - DATA: then every BAUD_DIV clocks, 8 data bits, LSB first.
  - STOP: stop bit sampled. Sample 1 yields a byte-valid pulse (1 clk). Sample 0 is a framing error: byte dropped, assembler returns to HIGH.
  - The engine is back in IDLE the cycle after the stop sample.
- Byte assembler, states HIGH, LOW:
  - HIGH + byte valid: latch high byte; go to LOW; clear and start the timeout counter.
  - LOW + byte valid: cmd <= {high, low}, registered. cmd_rdy=1 on the same edge. Go to HIGH.
  - LOW with the counter reaching BYTE_TIMEOUT before a start bit is detected: discard high byte; go to HIGH. cmd is unchanged.
  - cmd_rdy is also cleared at the first byte-valid of the next command, so stale commands never persist.
  - clr_cmd_rdy and command completion in the same cycle: set wins (cmd_rdy=1).
  - cmd holds its value until the next complete command; it is not cleared by clr_cmd_rdy.
- TX engine, states IDLE, TXING:
  - trmt in IDLE: latch resp into a 10-bit shift {1, resp, 0}; tx_done <= 0; go to TXING.
  - TXING: shift one bit every BAUD_DIV clocks, LSB (start bit) first. The frame is exactly 10*BAUD_DIV clocks.
  - After the stop bit period: TX=1, tx_done=1 (held), go to IDLE.
  - trmt while TXING is ignored; resp is not re-latched.
  - TX is registered, glitch-free, and 1 whenever not mid-frame.
- RX and TX are fully independent; full duplex is supported.
- Latency: cmd_rdy rises 1 clk after the low byte's stop-bit sample edge. The TX start bit appears 1 clk after trmt.

Decomposition:
- Shared package (knight_pkg), for use by the command FSM and benches:
  - constants POS_ACK=8'hA5, NEG_ACK=8'h5A
  - typedef rx_state_t {IDLE, START, DATA, STOP}
  - typedef tx_state_t {TX_IDLE, TXING}
  - typedef asm_state_t {HIGH, LOW}
- One sub-module: uart_byte_rx (sync, bit engine, byte-valid, framing error).
- TX engine and assembler stay in cmd_uart_wrapper.

Test Plan (BAUD_DIV=16, BYTE_TIMEOUT=2000):
1. Host sends 8'h47 then 8'hF1 -> cmd=16'h47F1, cmd_rdy=1 exactly 1 clk after the second stop sample. clr_cmd_rdy pulse -> cmd_rdy=0 next clk, cmd stays 16'h47F1.
2. trmt with resp=8'hA5 -> TX line shows 0,1,0,1,0,0,1,0,1,1, each 16 clks. tx_done=1 at clk 161 after trmt. A second trmt at clk 40 is ignored.
3. Send 8'h20 only, wait 2000+ clks, then send 8'h06 and 8'h05 -> cmd=16'h0605 (not 16'h2006).
4. Byte with stop bit forced 0, then a valid pair 8'h12, 8'h34 -> no cmd_rdy from the bad byte; cmd=16'h1234.
5. RX low pulse of 4 clks while idle -> no byte, state back to IDLE. Assert rst mid-TX frame -> TX=1, tx_done=0 next clk.
6. clr_cmd_rdy asserted on the exact completion cycle of 16'hA5A5 -> cmd_rdy=1. Simultaneous RX of a command and a TX of 8'h5A -> both correct.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared constants and state types for the Knight remote command link.
// Used by the UART wrapper, the command FSM and the benches.
package knight_pkg;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'h5A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TXING}          tx_state_t;
  typedef enum logic       {HIGH, LOW}               asm_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// UART receive bit engine: synchronizes RX, frames 8N1 bytes and reports
// a one-cycle byte-valid or framing-error strobe on the stop-bit sample.
module uart_byte_rx
  import knight_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic       start_det_o,
  output logic       busy_o
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
  localparam logic [CW-1:0] LAST      = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    byte_vld_o  = 1'b0;
    frame_err_o = 1'b0;
    start_det_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          start_det_o = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          state_d     = IDLE;
          byte_vld_o  = rx_sync_q;
          frame_err_o = !rx_sync_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data_o = shreg_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Knight-side command link: assembles two received bytes into a 16-bit
// command with a ready/clear handshake, and serializes response bytes.
module cmd_uart_wrapper
  import knight_pkg::*;
#(
  parameter int BAUD_DIV     = 5208,
  parameter int BYTE_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST    = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BYTE_TIMEOUT - 1);

  logic [7:0] rx_data;
  logic       byte_vld, frame_err, start_det, rx_busy;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (RX),
    .rx_data_o  (rx_data),
    .byte_vld_o (byte_vld),
    .frame_err_o(frame_err),
    .start_det_o(start_det),
    .busy_o     (rx_busy)
  );

  asm_state_t    asm_q, asm_d;
  logic [7:0]    high_q, high_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;

  tx_state_t     tx_state_q, tx_state_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d, tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q      <= HIGH;
      high_q     <= '0;
      to_cnt_q   <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      high_q     <= high_d;
      to_cnt_q   <= to_cnt_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Completion overrides the consumer's clear issued in the same cycle.
  always_comb begin
    asm_d     = asm_q;
    high_d    = high_q;
    to_cnt_d  = to_cnt_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    case (asm_q)
      HIGH: begin
        if (byte_vld) begin
          high_d    = rx_data;
          asm_d     = LOW;
          to_cnt_d  = '0;
          cmd_rdy_d = 1'b0;
        end
      end
      LOW: begin
        if (byte_vld) begin
          cmd_d     = {high_q, rx_data};
          cmd_rdy_d = 1'b1;
          asm_d     = HIGH;
        end else if (frame_err) begin
          asm_d = HIGH;
        end else if (!rx_busy && !start_det) begin
          if (to_cnt_q == TO_LAST) asm_d    = HIGH;
          else                     to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: asm_d = HIGH;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (trmt) begin
          tx_sh_d    = {1'b1, resp, 1'b0};
          tx_d       = 1'b0;
          tx_done_d  = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TXING;
        end
      end
      TXING: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_d       = 1'b1;
            tx_done_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = tx_sh_q[1];
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX      = tx_q;
  assign tx_done = tx_done_q;
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule
